// File: rtl/video_dither_pkg.sv
// Shared types, the 4x4 ordered-dither matrix and offset scaling for video_dither.
package video_dither_pkg;

    // Signed dither offset; wide enough for the scaled range -8..+6.
    typedef logic signed [3:0] dither_ofs_t;

    // Console GPU ordered-dither matrix, indexed [row y][column x].
    localparam dither_ofs_t DITHER_MATRIX [0:3][0:3] = '{
        '{-4'sd4,  4'sd0, -4'sd3,  4'sd1},
        '{ 4'sd2, -4'sd2,  4'sd3, -4'sd1},
        '{-4'sd3,  4'sd1, -4'sd4,  4'sd0},
        '{ 4'sd3, -4'sd1,  4'sd2, -4'sd2}
    };

    // The matrix is tuned for 5-bit output; other depths rescale the step size.
    function automatic dither_ofs_t scale_ofs(input dither_ofs_t ofs, input int out_bits);
        dither_ofs_t scaled;
        case (out_bits)
            4:       scaled = ofs <<< 1;
            6:       scaled = ofs >>> 1;
            7:       scaled = ofs >>> 2;
            default: scaled = ofs;
        endcase
        return scaled;
    endfunction

endpackage

// File: rtl/video_dither_channel.sv
// One colour channel of the output stage: add offset, clamp, quantize, re-expand.
module dither_channel
    import video_dither_pkg::*;
#(
    parameter int OUT_BITS = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce_pixel,
    input  logic [7:0]  color,
    input  dither_ofs_t offset,
    input  logic        en,
    output logic [7:0]  color_out
);

    localparam int REP_BITS = 8 - OUT_BITS;

    logic signed [9:0]   sum;
    logic [7:0]          clamped;
    logic [OUT_BITS-1:0] q;
    logic [7:0]          color_out_d;
    logic [7:0]          color_out_q;

    // Dither, saturate to 0..255, truncate to OUT_BITS and replicate the MSBs into the LSBs.
    always_comb begin
        sum = $signed({2'b00, color}) + $signed({{6{offset[3]}}, offset});
        if (sum[9]) begin
            clamped = 8'h00;
        end else if (sum[8]) begin
            clamped = 8'hFF;
        end else begin
            clamped = sum[7:0];
        end
        q = OUT_BITS'(clamped >> REP_BITS);
        color_out_d = color_out_q;
        if (ce_pixel) begin
            color_out_d = en ? {q, q[OUT_BITS-1 -: REP_BITS]} : color;
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            color_out_q <= 8'h00;
        end else begin
            color_out_q <= color_out_d;
        end
    end

    assign color_out = color_out_q;

endmodule

// File: rtl/video_dither.sv
// Ordered-dither quantizer for the video output path with matched sync delay.
//
// Stream qualifier: ce_pixel marks a pixel transfer. A pixel and its blank/sync
// flags are taken on every rising clk edge where ce_pixel=1; with ce_pixel=0
// every register (counters, both pipeline stages) holds. There is no
// backpressure. Each pixel appears on the outputs exactly two ce_pixel cycles
// after it was taken. OUT_BITS must lie in 4..7.
module video_dither
    import video_dither_pkg::*;
#(
    parameter int OUT_BITS = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce_pixel,
    input  logic       enable,
    input  logic       hblank,
    input  logic       vblank,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    output logic       hblank_out,
    output logic       vblank_out,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic [7:0] red_out,
    output logic [7:0] green_out,
    output logic [7:0] blue_out
);

    // Matrix position counters and line-edge detector.
    logic [1:0]  x_cnt_d, x_cnt_q;
    logic [1:0]  y_cnt_d, y_cnt_q;
    logic        prev_hblank_d, prev_hblank_q;

    // Stage 1: sampled pixel, its offset and the effective enable.
    logic [7:0]  s1_red_d, s1_red_q;
    logic [7:0]  s1_green_d, s1_green_q;
    logic [7:0]  s1_blue_d, s1_blue_q;
    dither_ofs_t s1_ofs_d, s1_ofs_q;
    logic        s1_en_d, s1_en_q;

    // Blank/sync pipeline, packed as {hblank, vblank, hsync, vsync}.
    logic [3:0]  s1_sync_d, s1_sync_q;
    logic [3:0]  sync_out_d, sync_out_q;

    // Column counter restarts every line; row counter advances on each hblank rising edge.
    always_comb begin
        x_cnt_d       = x_cnt_q;
        y_cnt_d       = y_cnt_q;
        prev_hblank_d = prev_hblank_q;
        if (ce_pixel) begin
            x_cnt_d       = hblank ? 2'd0 : x_cnt_q + 2'd1;
            prev_hblank_d = hblank;
            if (vblank) begin
                y_cnt_d = 2'd0;
            end else if (hblank && !prev_hblank_q) begin
                y_cnt_d = y_cnt_q + 2'd1;
            end
        end
    end

    // Stage 1 capture; the offset uses the counter values before this pixel's update.
    always_comb begin
        s1_red_d   = s1_red_q;
        s1_green_d = s1_green_q;
        s1_blue_d  = s1_blue_q;
        s1_ofs_d   = s1_ofs_q;
        s1_en_d    = s1_en_q;
        s1_sync_d  = s1_sync_q;
        sync_out_d = sync_out_q;
        if (ce_pixel) begin
            s1_red_d   = red;
            s1_green_d = green;
            s1_blue_d  = blue;
            s1_ofs_d   = scale_ofs(DITHER_MATRIX[y_cnt_q][x_cnt_q], OUT_BITS);
            s1_en_d    = enable & ~hblank & ~vblank;
            s1_sync_d  = {hblank, vblank, hsync, vsync};
            sync_out_d = s1_sync_q;
        end
    end

    // State registers for counters, stage 1 and the sync delay line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_cnt_q       <= 2'd0;
            y_cnt_q       <= 2'd0;
            prev_hblank_q <= 1'b0;
            s1_red_q      <= 8'h00;
            s1_green_q    <= 8'h00;
            s1_blue_q     <= 8'h00;
            s1_ofs_q      <= '0;
            s1_en_q       <= 1'b0;
            s1_sync_q     <= 4'h0;
            sync_out_q    <= 4'h0;
        end else begin
            x_cnt_q       <= x_cnt_d;
            y_cnt_q       <= y_cnt_d;
            prev_hblank_q <= prev_hblank_d;
            s1_red_q      <= s1_red_d;
            s1_green_q    <= s1_green_d;
            s1_blue_q     <= s1_blue_d;
            s1_ofs_q      <= s1_ofs_d;
            s1_en_q       <= s1_en_d;
            s1_sync_q     <= s1_sync_d;
            sync_out_q    <= sync_out_d;
        end
    end

    assign {hblank_out, vblank_out, hsync_out, vsync_out} = sync_out_q;

    dither_channel #(.OUT_BITS(OUT_BITS)) u_red (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce_pixel  (ce_pixel),
        .color     (s1_red_q),
        .offset    (s1_ofs_q),
        .en        (s1_en_q),
        .color_out (red_out)
    );

    dither_channel #(.OUT_BITS(OUT_BITS)) u_green (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce_pixel  (ce_pixel),
        .color     (s1_green_q),
        .offset    (s1_ofs_q),
        .en        (s1_en_q),
        .color_out (green_out)
    );

    dither_channel #(.OUT_BITS(OUT_BITS)) u_blue (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce_pixel  (ce_pixel),
        .color     (s1_blue_q),
        .offset    (s1_ofs_q),
        .en        (s1_en_q),
        .color_out (blue_out)
    );

endmodule

// File: doc/video_dither.md
Name: video_dither

Overview:
Ordered-dither quantizer for the video output path: the producer-side counterpart of the dither-removal blender. It reduces 8-bit RGB to OUT_BITS per channel using the 4x4 console GPU dither matrix, then re-expands to 8 bits by bit replication. It sits on the pixel-enable-qualified video stream with the blanking and sync signals, and delays those signals to match the data latency.

Parameters:
OUT_BITS, 5, quantized bits per channel; legal range 4..7.

Ports:
clk  in  1  pixel-domain clock
reset_n  in  1  asynchronous active-low reset
ce_pixel  in  1  pixel enable; all state advances only when it is high
enable  in  1  1 = dither and quantize; 0 = pass-through with the same latency
hblank  in  1  horizontal blank
vblank  in  1  vertical blank
hsync  in  1  horizontal sync
vsync  in  1  vertical sync
red  in  8  input red
green  in  8  input green
blue  in  8  input blue
hblank_out  out  1  hblank delayed 2 ce_pixel
vblank_out  out  1  vblank delayed 2 ce_pixel
hsync_out  out  1  hsync delayed 2 ce_pixel
vsync_out  out  1  vsync delayed 2 ce_pixel
red_out  out  8  processed red
green_out  out  8  processed green
blue_out  out  8  processed blue

Behaviour:
- Reset (reset_n=0, asynchronous): all outputs, pipeline registers, counters and the previous-hblank flag go to 0. A reset in mid-line or mid-frame is legal; the first pixel after release uses matrix position (0,0).
- When ce_pixel=0, every register holds its value. Latency is exactly 2 ce_pixel cycles for both data and sync.
- x_cnt (2 bits): cleared on a ce_pixel cycle with hblank=1; otherwise incremented on each ce_pixel cycle, wrapping from 3 to 0.
- y_cnt (2 bits): cleared on a ce_pixel cycle with vblank=1; otherwise incremented on a ce_pixel cycle with hblank=1 and prev_hblank=0 (rising edge), wrapping from 3 to 0. If vblank and the hblank rising edge occur together, the clear wins.
- Offset lookup: uses the pre-update (x_cnt, y_cnt) for the current input pixel. Row y, columns x=0..3:
  - row 0: -4 0 -3 1
  - row 1: 2 -2 3 -1
  - row 2: -3 1 -4 0
  - row 3: 3 -1 2 -2
  - Scaling by OUT_BITS: 4 → offset shifted left by 1; 5 → unchanged; 6 → arithmetic shift right by 1; 7 → arithmetic shift right by 2.
- Stage 1 (registered): input colors, the signed 4-bit offset, the blank flags, and an effective-enable bit. The effective-enable bit is enable & ~hblank & ~vblank.
- Stage 2 (registered outputs), per channel:
  - sum = color + offset in 10-bit signed arithmetic.
  - Clamp the sum to 0..255.
  - q = clamped[7:8-OUT_BITS].
  - out = {q, q[OUT_BITS-1 -: 8-OUT_BITS]} (bit replication).
- When the effective-enable bit is 0, the channel outputs the stage-1 color unmodified.
- enable is sampled per pixel; toggling it mid-line affects only pixels sampled after the change.

Decomposition:
- Package video_dither_pkg holds:
  - the 4x4 signed dither matrix constant;
  - typedef dither_ofs_t (signed 4-bit);
  - the scaling function for OUT_BITS.
- Sub-module dither_channel holds the stage-2 add/clamp/quantize/replicate for one 8-bit channel. It is instantiated 3 times, with inputs color, offset and en.
- Counters, lookup and the sync pipeline stay in video_dither.

Test Plan:
- Reset: hold reset_n=0 with random inputs → all outputs 0. Release, then drive hblank=1 → hblank_out rises exactly 2 ce_pixel later.
- Ordered pattern, row 0 (OUT_BITS=5, enable=1, after a vblank clear): drive red=97 for 4 active pixels → red_out = 90, 99, 90, 99 (q = 11, 12, 11, 12).
- Clamping:
  - On row 3, x=0 (offset +3), red=254 → 255.
  - On row 0, x=0 (offset -4), red=2 → 0.
- Pass-through and blanking: with enable=0, red=97 → red_out=97 after 2 ce_pixel. With enable=1 during hblank=1, red=97 → red_out=97.
- Counters:
  - Each hblank rising edge advances the row: the 5th line reuses row 0's pattern.
  - vblank together with an hblank rising edge leaves y_cnt=0.
  - Gating ce_pixel low for 3 cycles mid-line freezes outputs and x_cnt.
- OUT_BITS=6 sweep: red=100 on row 1 (scaled offsets 1, -1, 1, -1) → q = 25, 24, 25, 24 → red_out = 101, 97, 101, 97.
